// File: rtl/aes128_reg_core_bridge.sv
// Register-strobe to AES-128 core bridge: packs key/plaintext words, runs one valid/ready request,
// captures ciphertext, reports status and a saturating cycle count. Optional macro: AES128_SCA_TRIGGER_EN.
module aes128_reg_core_bridge #(
    parameter int ADDR_W         = 4,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              reg_wr_en,
    input  logic [ADDR_W-1:0] reg_wr_addr,
    input  logic [31:0]       reg_wr_data,
    input  logic              reg_rd_en,
    input  logic [ADDR_W-1:0] reg_rd_addr,
    output logic [31:0]       reg_rd_data,
    output logic              core_valid,
    input  logic              core_ready,
    output logic [127:0]      core_key,
    output logic [127:0]      core_pt,
    input  logic              core_ct_valid,
    input  logic [127:0]      core_ct,
`ifdef AES128_SCA_TRIGGER_EN
    output logic              trigger,
`endif
    output logic              busy,
    output logic [1:0]        fsm_state
);

    // Core handshake: a request transfers on the cycle core_valid && core_ready are both high;
    // core_valid only drops after that cycle and key/pt cannot change while it is high.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam int          EXT_W   = (CNT_W > 32) ? CNT_W : 32;
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t             state;
    state_t             state_next;
    logic [31:0]        key [4];
    logic [31:0]        pt  [4];
    logic [31:0]        ct  [4];
    logic               done;
    logic               err;
    logic [CNT_W-1:0]   cycles;
    logic [EXT_W-1:0]   cycles_ext;
    logic [31:0]        wait_cnt;
    logic [31:0]        rd_mux;
    logic               start_wr;
    logic               key_wr;
    logic               pt_wr;
    logic               timeout_hit;
    logic               finish_ok;
    logic               finish_to;

    assign start_wr    = reg_wr_en && (reg_wr_addr == ADDR_W'(8)) && reg_wr_data[0];
    assign key_wr      = reg_wr_en && (reg_wr_addr[ADDR_W-1:2] == '0);
    assign pt_wr       = reg_wr_en && (reg_wr_addr[ADDR_W-1:2] == (ADDR_W-2)'(1));
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == TO_LAST);
    assign cycles_ext  = EXT_W'(cycles);
    assign core_key    = {key[3], key[2], key[1], key[0]};
    assign core_pt     = {pt[3], pt[2], pt[1], pt[0]};
    assign fsm_state   = state;

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        core_valid = 1'b0;
        busy       = 1'b0;
        finish_ok  = 1'b0;
        finish_to  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_wr) state_next = ST_REQ;
            end
            ST_REQ: begin
                core_valid = 1'b1;
                busy       = 1'b1;
                if (core_ready) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                // A ciphertext arriving on the timeout cycle still wins.
                if (core_ct_valid) begin
                    finish_ok  = 1'b1;
                    state_next = ST_IDLE;
                end else if (timeout_hit) begin
                    finish_to  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        if (reg_rd_addr[ADDR_W-1:2] == '0)
            rd_mux = key[reg_rd_addr[1:0]];
        else if (reg_rd_addr[ADDR_W-1:2] == (ADDR_W-2)'(1))
            rd_mux = pt[reg_rd_addr[1:0]];
        else if (reg_rd_addr == ADDR_W'(9))
            rd_mux = {29'd0, err, done, busy};
        else if (reg_rd_addr == ADDR_W'(10))
            rd_mux = cycles_ext[31:0];
        else if (reg_rd_addr[ADDR_W-1:2] == (ADDR_W-2)'(3))
            rd_mux = ct[reg_rd_addr[1:0]];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                key[i] <= '0;
                pt[i]  <= '0;
                ct[i]  <= '0;
            end
            done        <= 1'b0;
            err         <= 1'b0;
            cycles      <= '0;
            wait_cnt    <= '0;
            reg_rd_data <= '0;
        end else begin
            // Register side only touches key/pt/start while the FSM is idle.
            if (state == ST_IDLE) begin
                if (key_wr) key[reg_wr_addr[1:0]] <= reg_wr_data;
                if (pt_wr)  pt[reg_wr_addr[1:0]]  <= reg_wr_data;
                if (start_wr) begin
                    done   <= 1'b0;
                    err    <= 1'b0;
                    cycles <= '0;
                end
            end
            if ((state == ST_REQ || state == ST_WAIT) && (cycles != '1))
                cycles <= cycles + 1'b1;
            if (state == ST_REQ && core_ready)
                wait_cnt <= '0;
            else if (state == ST_WAIT)
                wait_cnt <= wait_cnt + 32'd1;
            if (finish_ok) begin
                for (int i = 0; i < 4; i++) ct[i] <= core_ct[32*i +: 32];
                done <= 1'b1;
            end
            if (finish_to) begin
                err  <= 1'b1;
                done <= 1'b0;
            end
            if (reg_rd_en) reg_rd_data <= rd_mux;
        end
    end

`ifdef AES128_SCA_TRIGGER_EN
    // High for exactly the cycles the core is computing (post-handshake until result or abort).
    always_ff @(posedge clock) begin
        if (reset) trigger <= 1'b0;
        else       trigger <= (state_next == ST_WAIT);
    end
`endif

endmodule
